// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined adder:
//   - op_e        : operation select carried on the 'sub' input (ADD / SUB)
//   - DEFAULT_*   : default operand width and pipeline depth
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CW-bit ripple-carry adder slice used once per pipeline stage.
// Ports:
//   a_i, b_i  : CW-bit operand slices
//   cin_i     : carry into bit 0 of the slice
//   sum_o     : CW-bit slice sum
//   cout_o    : carry out of the slice MSB
// -----------------------------------------------------------------------------
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o
);

  logic [CW:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < CW; gi++) begin : g_bit
    assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[CW];

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Valid/ready pipelined adder/subtractor. The operands are cut into STAGES
// chunks of CW = WIDTH/STAGES bits; stage k adds chunk k with the carry
// registered by stage k-1. Not-yet-added upper operand chunks travel forward
// with the partial sum so every chunk of one operation leaves together,
// STAGES cycles after the input transfer.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = pipeline may advance)
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + 1 (cin ignored)
//   out_valid/out_ready : output handshake
//   sum, cout, overflow : result, carry out of MSB (1 = no borrow on sub),
//                         signed overflow
//   zero                : sum == 0, only when PIPE_ADDER_ZERO_FLAG_EN is defined
//
// Optional feature macro: PIPE_ADDER_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
`ifdef PIPE_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_width_check
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  // The whole pipe moves as one: it stalls only when a result is waiting
  // at the output and nobody is taking it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign b_eff  = (op_e'(sub) == SUB) ? ~b : b;
  assign carry0 = (op_e'(sub) == SUB) ? 1'b1 : cin;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // REM_IN: operand bits entering this stage that are still to be added
    // (this stage's chunk in the low CW bits). DONE_OUT: result bits known
    // after this stage.
    localparam int REM_IN   = WIDTH - gi * CW;
    localparam int DONE_OUT = (gi + 1) * CW;

    logic [REM_IN-1:0]   a_in;
    logic [REM_IN-1:0]   b_in;
    logic                c_in;
    logic                v_in;
    logic [CW-1:0]       s_chunk;
    logic                c_chunk;
    logic [DONE_OUT-1:0] sum_d;
    logic [DONE_OUT-1:0] sum_q;
    logic                v_q;
    logic                c_q;

    if (gi == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = carry0;
      assign v_in  = in_valid;
      assign sum_d = s_chunk;
    end else begin : g_body
      assign a_in  = g_stage[gi-1].g_fwd.a_q;
      assign b_in  = g_stage[gi-1].g_fwd.b_q;
      assign c_in  = g_stage[gi-1].c_q;
      assign v_in  = g_stage[gi-1].v_q;
      assign sum_d = {s_chunk, g_stage[gi-1].sum_q};
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i   (a_in[CW-1:0]),
      .b_i   (b_in[CW-1:0]),
      .cin_i (c_in),
      .sum_o (s_chunk),
      .cout_o(c_chunk)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= c_chunk;
        sum_q <= sum_d;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      // Upper operand chunks not yet consumed, shifted so the next stage
      // always finds its chunk in the low CW bits.
      logic [REM_IN-CW-1:0] a_q;
      logic [REM_IN-CW-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[REM_IN-1:CW];
          b_q <= b_in[REM_IN-1:CW];
        end
      end
    end else begin : g_tail
      // The last chunk holds both operand MSBs, so overflow is resolved here
      // and registered alongside the final sum.
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_in[CW-1] == b_in[CW-1]) && (s_chunk[CW-1] != a_in[CW-1]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end

`ifdef PIPE_ADDER_ZERO_FLAG_EN
      logic zero_d;
      logic zero_q;

      assign zero_d = (sum_d == '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          zero_q <= 1'b0;
        end else if (advance) begin
          zero_q <= zero_d;
        end
      end
`endif
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_tail.ovf_q;
`ifdef PIPE_ADDER_ZERO_FLAG_EN
  assign zero      = g_stage[STAGES-1].g_tail.zero_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Directed table vectors, back-pressure and reset sequences on a default
// (32/4) instance, then randomized traffic on a 64/8 instance, all checked
// against an arithmetic reference model and a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  localparam int LAT32  = 4;
  localparam int N_RAND = 15000;
  localparam int MAX_CYC = 60000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic        iv32, ir32, ovl32, ordy32, cin32, sub32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;
  // wide instance
  logic        iv64, ir64, ovl64, ordy64, cin64, sub64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;
`ifdef PIPE_ADDER_ZERO_FLAG_EN
  logic        zero32, zero64;
`endif

  pipe_adder dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ovl32), .out_ready(ordy32),
    .sum(sum32), .cout(cout32), .overflow(ovf32)
`ifdef PIPE_ADDER_ZERO_FLAG_EN
    , .zero(zero32)
`endif
  );

  pipe_adder #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .cin(cin64), .sub(sub64),
    .out_valid(ovl64), .out_ready(ordy64),
    .sum(sum64), .cout(cout64), .overflow(ovf64)
`ifdef PIPE_ADDER_ZERO_FLAG_EN
    , .zero(zero64)
`endif
  );

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout, ovf;
    int          cyc;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t pend32, pend64;
  int   cyc32 = 0;
  logic lat_chk = 1'b0;
  logic acc32, acc64;
  int   n_out64 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got output with no expected entry, expected none", name);
  endtask

  // Reference: plain integer arithmetic. Returns {overflow, cout, sum}.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0]        mask, s;
    logic [65:0]        ua, ub, full;
    logic signed [66:0] sa, sb, res, hi, lo, cin_s;
    logic               co, ov;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua    = {2'b00, a & mask};
    ub    = {2'b00, (sub ? ~b : b) & mask};
    full  = ua + ub + (sub ? 66'd1 : {65'd0, cin});
    s     = full[63:0] & mask;
    co    = full[w];
    sa    = $signed({3'b000, a & mask});
    sb    = $signed({3'b000, b & mask});
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    cin_s = $signed({66'd0, cin});
    res   = sub ? (sa - sb) : (sa + sb + cin_s);
    hi    = (67'sd1 <<< (w - 1)) - 67'sd1;
    lo    = -(67'sd1 <<< (w - 1));
    ov    = (res > hi) || (res < lo);
    return {ov, co, s};
  endfunction

  // One cycle on the 32-bit instance: inputs were driven at the negedge.
  task automatic step32();
    exp_t e;
    #1;
    acc32 = iv32 && ir32;
    if (ovl32 && ordy32) begin
      if (q32.size() == 0) fail_now("unexpected_out32");
      else begin
        e = q32.pop_front();
        check("sum32", sum32, e.sum[31:0]);
        check("cout32", cout32, e.cout);
        check("ovf32", ovf32, e.ovf);
`ifdef PIPE_ADDER_ZERO_FLAG_EN
        check("zero32", zero32, e.sum[31:0] == 32'd0);
`endif
        if (lat_chk) check("latency32", cyc32 - e.cyc, LAT32);
      end
    end
    if (acc32) begin
      e     = pend32;
      e.cyc = cyc32;
      q32.push_back(e);
    end
    cyc32++;
    @(negedge clk);
  endtask

  task automatic step64();
    exp_t e;
    #1;
    acc64 = iv64 && ir64;
    if (ovl64 && ordy64) begin
      if (q64.size() == 0) fail_now("unexpected_out64");
      else begin
        e = q64.pop_front();
        n_out64++;
        check("rand64_ovf_cout_sum", {ovf64, cout64, sum64}, {e.ovf, e.cout, e.sum});
      end
    end
    if (acc64) q64.push_back(pend64);
    @(negedge clk);
  endtask

  task automatic new_op32();
    logic [65:0] r;
    a32   = $urandom;
    b32   = $urandom;
    cin32 = 1'($urandom_range(0, 1));
    sub32 = 1'($urandom_range(0, 1));
    r     = ref_add(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32);
    pend32.sum  = r[63:0];
    pend32.cout = r[64];
    pend32.ovf  = r[65];
  endtask

  function automatic logic [63:0] pick64();
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 3))
        0:       return 64'd0;
        1:       return {64{1'b1}};
        2:       return 64'h8000_0000_0000_0000;
        default: return 64'h7FFF_FFFF_FFFF_FFFF;
      endcase
    end
    return {$urandom, $urandom};
  endfunction

  task automatic new_op64();
    logic [65:0] r;
    a64   = pick64();
    b64   = pick64();
    cin64 = 1'($urandom_range(0, 1));
    sub64 = 1'($urandom_range(0, 1));
    r     = ref_add(64, a64, b64, cin64, sub64);
    pend64.sum  = r[63:0];
    pend64.cout = r[64];
    pend64.ovf  = r[65];
    pend64.cyc  = 0;
  endtask

  // Issue n_ops, then assert reset asynchronously in the middle of a cycle.
  task automatic rst_test(input int n_ops);
    int stale;
    ordy32  = 1'b1;
    lat_chk = 1'b0;
    for (int i = 0; i < n_ops; i++) begin
      iv32 = 1'b1;
      new_op32();
      step32();
    end
    iv32 = 1'b0;
    #2;
    if (n_ops > LAT32) check("pre_reset_out_valid", ovl32, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_out_valid", ovl32, 1'b0);
    check("rst_sum", sum32, 32'd0);
    check("rst_cout", cout32, 1'b0);
    check("rst_overflow", ovf32, 1'b0);
    q32.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_release", ir32, 1'b1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (ovl32) stale++;
    end
    check("no_stale_after_reset", stale, 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   stall_seen;
    int   cyc;
    int   issued;

    tbl[0] = '{32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'd1,          1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'd5,         32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'd3,         32'd3,          1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h1234_5678, 32'h0FED_CBA9,  1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};

    rst = 1'b1;
    iv32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; ordy64 = 1'b1;

    // Reset holds everything at zero even with clocks and offered input.
    repeat (6) @(negedge clk);
    check("reset_out_valid", ovl32, 1'b0);
    check("reset_sum", sum32, 32'd0);
    check("reset_cout", cout32, 1'b0);
    check("reset_overflow", ovf32, 1'b0);
    iv32 = 1'b0;
    rst  = 1'b0;
    #1;
    check("in_ready_first_cycle", ir32, 1'b1);
    @(negedge clk);

    // Table vectors: one op each, latency checked.
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iv32 = 1'b1;
      a32 = tbl[i].a; b32 = tbl[i].b; cin32 = tbl[i].cin; sub32 = tbl[i].sub;
      pend32.sum  = {32'd0, tbl[i].sum};
      pend32.cout = tbl[i].cout;
      pend32.ovf  = tbl[i].ovf;
      step32();
      iv32 = 1'b0;
      repeat (LAT32 + 1) step32();
    end
    check("table_drain", q32.size(), 0);

    // Back-to-back throughput: each result must still arrive after exactly 4 cycles.
    for (int i = 0; i < 8; i++) begin
      iv32 = 1'b1;
      new_op32();
      step32();
    end
    iv32 = 1'b0;
    repeat (LAT32 + 2) step32();
    check("stream_drain", q32.size(), 0);

    // Back-pressure: 3 ops, then a source that keeps offering while output stalls.
    lat_chk = 1'b0;
    ordy32  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv32 = 1'b1;
      new_op32();
      step32();
    end
    new_op32();
    stall_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (ovl32) begin
        stall_seen++;
        check("stall_in_ready", ir32, 1'b0);
        check("stall_hold", {ovf32, cout32, sum32}, {q32[0].ovf, q32[0].cout, q32[0].sum[31:0]});
      end
      step32();
      if (acc32) new_op32();
    end
    check("stall_seen", stall_seen > 0, 1'b1);
    ordy32 = 1'b1;
    while (!acc32) step32();
    iv32 = 1'b0;
    repeat (LAT32 + 4) step32();
    check("bp_drain", q32.size(), 0);

    // Reset mid-flight: early (nothing at output yet) and with output valid.
    rst_test(2);
    rst_test(6);

    // Randomized traffic on the wide instance with random back-pressure.
    cyc    = 0;
    issued = 0;
    acc64  = 1'b0;
    while (n_out64 < N_RAND && cyc < MAX_CYC) begin
      if (!iv64 || acc64) begin
        if (issued < N_RAND && $urandom_range(0, 3) != 0) begin
          new_op64();
          iv64 = 1'b1;
          issued++;
        end else begin
          iv64 = 1'b0;
        end
      end
      ordy64 = ($urandom_range(0, 3) != 0);
      step64();
      cyc++;
    end
    check("rand64_all_out", n_out64, N_RAND);
    check("rand64_queue_empty", q64.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
